// File: rtl/load_store_unit.sv
// Memory stage: issues one data-memory access per accepted load/store and returns a writeback record.
// Stores complete one cycle after grant, loads one cycle after rvalid, faults the cycle after accept.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        lsu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_d;
  logic        mem_req_d, mem_we_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [3:0]  mem_wstrb_d;
  logic        wb_valid_d, wb_fault_d;
  logic [4:0]  wb_rd_d;
  logic [31:0] wb_data_d;
  logic [2:0]  ld_funct3, ld_funct3_d;
  logic [1:0]  ld_off, ld_off_d;
  logic [4:0]  ld_rd, ld_rd_d;

  logic        accept, ld_ok, st_ok, illegal, misaligned;
  logic [3:0]  st_strb;
  logic [31:0] st_data, ld_shift, ld_ext;

  assign lsu_ready  = (state == IDLE);
  assign accept     = ex_valid && lsu_ready && (ex_load || ex_store);
  assign ld_ok      = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign st_ok      = ex_funct3 inside {3'b000, 3'b001, 3'b010};
  assign illegal    = (ex_load && ex_store) || (ex_load && !ld_ok) || (ex_store && !st_ok);
  assign misaligned = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                      ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));

  always_comb begin
    st_strb = 4'b1111;
    st_data = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << ex_addr[1:0];
        st_data = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << ex_addr[1:0];
        st_data = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Byte offset was captured at accept; the response word is shifted down to lane 0.
  assign ld_shift = mem_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_ext = mem_rdata;
    case (ld_funct3)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wstrb_d = mem_wstrb;
    mem_wdata_d = mem_wdata;
    ld_funct3_d = ld_funct3;
    ld_off_d    = ld_off;
    ld_rd_d     = ld_rd;
    wb_valid_d  = 1'b0;
    wb_fault_d  = 1'b0;
    wb_rd_d     = 5'd0;
    wb_data_d   = 32'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (illegal || misaligned) begin
            wb_valid_d = 1'b1;
            wb_fault_d = 1'b1;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = ex_store;
            mem_addr_d  = {ex_addr[31:2], 2'b00};
            mem_wstrb_d = ex_store ? st_strb : 4'b0000;
            mem_wdata_d = ex_store ? st_data : 32'd0;
            ld_funct3_d = ex_funct3;
            ld_off_d    = ex_addr[1:0];
            ld_rd_d     = ex_rd;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'd0;
          if (mem_we) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = ld_rd;
          wb_data_d  = ld_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'd0;
      ld_funct3 <= 3'd0;
      ld_off    <= 2'd0;
      ld_rd     <= 5'd0;
      wb_valid  <= 1'b0;
      wb_fault  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
    end else begin
      state     <= state_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wstrb <= mem_wstrb_d;
      mem_wdata <= mem_wdata_d;
      ld_funct3 <= ld_funct3_d;
      ld_off    <= ld_off_d;
      ld_rd     <= ld_rd_d;
      wb_valid  <= wb_valid_d;
      wb_fault  <= wb_fault_d;
      wb_rd     <= wb_rd_d;
      wb_data   <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: expected writeback records are queued at issue and popped when wb_valid pulses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic        lsu_ready, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        wb_valid, wb_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        fault;
  } wb_t;

  wb_t exp_q[$];
  wb_t exp_e;
  int  total = 0;
  int  bad = 0;
  int  req_cnt = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .lsu_ready(lsu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  // Scoreboard: every writeback pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_req) req_cnt++;
    if (wb_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stray_wb: got rd=%0d data=%h fault=%b, required no writeback",
                 wb_rd, wb_data, wb_fault);
      end else begin
        exp_e = exp_q.pop_front();
        if ({wb_rd, wb_data, wb_fault} !== exp_e) begin
          bad++;
          $display("FAIL wb_record: got rd=%0d data=%h fault=%b, required rd=%0d data=%h fault=%b",
                   wb_rd, wb_data, wb_fault, exp_e.rd, exp_e.data, exp_e.fault);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_load = ld; ex_store = st;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    tick();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    total++;
    if ({lsu_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, wb_valid, wb_fault, wb_rd, wb_data}
        !== {1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset_values: got ready=%b req=%b we=%b addr=%h strb=%b wdata=%h wbv=%b flt=%b rd=%0d data=%h, required ready=1 rest 0",
               lsu_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, wb_valid, wb_fault, wb_rd, wb_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] strb,
                            input logic [31:0] lane, input int stall);
    exp_q.push_back('{rd: 5'd0, data: 32'd0, fault: 1'b0});
    issue(1'b0, 1'b1, f3, a, wd, 5'd7);
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) tick();
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, lsu_ready}
          !== {1'b1, 1'b1, {a[31:2], 2'b00}, strb, lane, 1'b0}) begin
        bad++;
        $display("FAIL %s req_cycle%0d: got req=%b we=%b addr=%h strb=%b wdata=%h ready=%b, required req=1 we=1 addr=%h strb=%b wdata=%h ready=0",
                 name, i, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, lsu_ready,
                 {a[31:2], 2'b00}, strb, lane);
      end
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    total++;
    if ({wb_valid, mem_req, lsu_ready} !== 3'b101) begin
      bad++;
      $display("FAIL %s after_gnt: got wbv=%b req=%b ready=%b, required 1 0 1", name, wb_valid, mem_req, lsu_ready);
    end
    tick();
    total++;
    if (wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s single_pulse: got wbv=%b, required 0", name, wb_valid);
    end
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] expd, input int lat, input logic rv_in_gnt);
    exp_q.push_back('{rd: rd, data: expd, fault: 1'b0});
    issue(1'b1, 1'b0, f3, a, 32'hCAFE_F00D, rd);
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {1'b1, 1'b0, {a[31:2], 2'b00}, 4'b0000}) begin
      bad++;
      $display("FAIL %s load_req: got req=%b we=%b addr=%h strb=%b, required req=1 we=0 addr=%h strb=0000",
               name, mem_req, mem_we, mem_addr, mem_wstrb, {a[31:2], 2'b00});
    end
    mem_gnt = 1'b1;
    if (rv_in_gnt) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5555_AAAA;
    end
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    total++;
    if ({mem_req, lsu_ready, wb_valid} !== 3'b000) begin
      bad++;
      $display("FAIL %s wait_state: got req=%b ready=%b wbv=%b, required 0 0 0", name, mem_req, lsu_ready, wb_valid);
    end
    repeat (lat) tick();
    mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    total++;
    if ({wb_valid, lsu_ready} !== 2'b11) begin
      bad++;
      $display("FAIL %s wb_timing: got wbv=%b ready=%b, required 1 1", name, wb_valid, lsu_ready);
    end
    tick();
    total++;
    if (wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s single_pulse: got wbv=%b, required 0", name, wb_valid);
    end
  endtask

  task automatic test_fault(input string name, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] a);
    int req_before;
    req_before = req_cnt;
    exp_q.push_back('{rd: 5'd0, data: 32'd0, fault: 1'b1});
    issue(ld, st, f3, a, 32'h1234_5678, 5'd9);
    total++;
    if ({wb_valid, wb_fault, lsu_ready, mem_req} !== 4'b1110) begin
      bad++;
      $display("FAIL %s fault_pulse: got wbv=%b flt=%b ready=%b req=%b, required 1 1 1 0",
               name, wb_valid, wb_fault, lsu_ready, mem_req);
    end
    repeat (2) tick();
    total++;
    if (req_cnt != req_before || wb_valid !== 1'b0 || lsu_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s no_request: got req_cycles=%0d wbv=%b ready=%b, required 0 0 1",
               name, req_cnt - req_before, wb_valid, lsu_ready);
    end
  endtask

  task automatic test_ignored();
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0; ex_addr = 32'h1000;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    ex_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    tick();
    total++;
    if ({mem_req, wb_valid, lsu_ready} !== 3'b001) begin
      bad++;
      $display("FAIL ignored_ops: got req=%b wbv=%b ready=%b, required 0 0 1", mem_req, wb_valid, lsu_ready);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{rd: 5'd0, data: 32'd0, fault: 1'b1});
    exp_q.push_back('{rd: 5'd0, data: 32'd0, fault: 1'b0});
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0;
    ex_funct3 = 3'b010; ex_addr = 32'h1002; ex_rd = 5'd4;
    tick();
    total++;
    if ({wb_valid, wb_fault, lsu_ready} !== 3'b111) begin
      bad++;
      $display("FAIL b2b_fault: got wbv=%b flt=%b ready=%b, required 1 1 1", wb_valid, wb_fault, lsu_ready);
    end
    ex_load = 1'b0; ex_store = 1'b1; ex_funct3 = 3'b000;
    ex_addr = 32'h1001; ex_wdata = 32'h0000_005A;
    tick();
    ex_valid = 1'b0; ex_store = 1'b0;
    total++;
    if ({mem_req, mem_wstrb, mem_wdata, wb_valid} !== {1'b1, 4'b0010, 32'h5A5A_5A5A, 1'b0}) begin
      bad++;
      $display("FAIL b2b_store: got req=%b strb=%b wdata=%h wbv=%b, required 1 0010 5a5a5a5a 0",
               mem_req, mem_wstrb, mem_wdata, wb_valid);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    total++;
    if (wb_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_store_wb: got wbv=%b, required 1", wb_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    issue(1'b1, 1'b0, 3'b010, 32'h2000, 32'd0, 5'd3);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({lsu_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, wb_valid, wb_fault, wb_rd, wb_data}
        !== {1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset_mid_load: got ready=%b req=%b wbv=%b rd=%0d data=%h, required ready=1 rest 0",
               lsu_ready, mem_req, wb_valid, wb_rd, wb_data);
    end
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    total++;
    if ({wb_valid, lsu_ready} !== 2'b01) begin
      bad++;
      $display("FAIL stale_rvalid: got wbv=%b ready=%b, required 0 1", wb_valid, lsu_ready);
    end
    test_load("lw_after_reset", 3'b010, 32'h2000, 5'd3, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_store("sw_stall", 3'b010, 32'h1000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 3);
    test_store("sb_lane3", 3'b000, 32'h1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 0);
    test_store("sh_upper", 3'b001, 32'h1002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 1);
    test_load("lb_1001", 3'b000, 32'h1001, 5'd5, 32'h80FF_7F01, 32'h0000_007F, 0, 1'b0);
    test_load("lb_1002", 3'b000, 32'h1002, 5'd6, 32'h80FF_7F01, 32'hFFFF_FFFF, 2, 1'b0);
    test_load("lbu_1003", 3'b100, 32'h1003, 5'd7, 32'h80FF_7F01, 32'h0000_0080, 1, 1'b1);
    test_load("lh_1002", 3'b001, 32'h1002, 5'd10, 32'h8001_ABCD, 32'hFFFF_8001, 0, 1'b1);
    test_load("lhu_1000", 3'b101, 32'h1000, 5'd11, 32'h8001_ABCD, 32'h0000_ABCD, 3, 1'b0);
    test_load("lw_1004", 3'b010, 32'h1004, 5'd31, 32'h8765_4321, 32'h8765_4321, 0, 1'b0);
    test_fault("lw_misaligned", 1'b1, 1'b0, 3'b010, 32'h1002);
    test_fault("sh_misaligned", 1'b0, 1'b1, 3'b001, 32'h1001);
    test_fault("load_f3_011", 1'b1, 1'b0, 3'b011, 32'h1000);
    test_fault("load_and_store", 1'b1, 1'b1, 3'b010, 32'h1000);
    test_fault("store_f3_100", 1'b0, 1'b1, 3'b100, 32'h1000);
    test_ignored();
    test_back_to_back();
    test_reset_mid_load();
    repeat (2) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_wb: got %0d outstanding expectations, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage of the single-issue core, directly downstream of the ALU. It takes the ALU result as the effective address of a load or store and runs a request/grant/response handshake with the data memory. It generates byte strobes and lane-shifted store data, then aligns and sign- or zero-extends the load data. It returns one writeback record per accepted operation and stalls the EX stage while an access is outstanding.

## Interface
- Parameters: none.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  EX presents a memory operation this cycle.
- ex_load  in  1  operation is a load.
- ex_store  in  1  operation is a store.
- ex_funct3  in  3  RV32I size/sign field.
- ex_addr  in  32  effective address (ALU result).
- ex_wdata  in  32  store data, right-aligned (rs2).
- ex_rd  in  5  load destination register.
- lsu_ready  out  1  unit can accept; EX must hold its operands while this is low.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, bits [1:0] forced to 0.
- mem_wstrb  out  4  byte-lane enables; 0000 on reads.
- mem_wdata  out  32  lane-shifted store data.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data, full word.
- wb_valid  out  1  one-cycle completion pulse.
- wb_rd  out  5  destination register; 0 for stores and faults.
- wb_data  out  32  extended load data; 0 for stores and faults.
- wb_fault  out  1  qualifies wb_valid; set for a misaligned or illegal operation.

## Operation
- The FSM has three states: IDLE, REQ and WAIT. lsu_ready = (state == IDLE).
- **Accept.** An operation is accepted when ex_valid && lsu_ready && (ex_load || ex_store). On accept, the unit registers addr, funct3, rd, direction and data.
- **Legal encodings.**
  - Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: funct3 000 SB, 001 SH, 010 SW.
  - Any other funct3, or ex_load && ex_store both set, is illegal.
- **Misaligned.** Halfword with addr[0] = 1, or word with addr[1:0] != 00.
- **Fault path.**
  - Trigger: an illegal or misaligned operation at accept.
  - The unit does not enter REQ and issues no memory request.
  - Next cycle: wb_valid = 1, wb_fault = 1, wb_rd = 0, wb_data = 0.
  - The FSM stays in IDLE.
- **Legal path.** The FSM moves IDLE → REQ.
  - mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata are registered and held stable until mem_gnt.
- **REQ.**
  - Store: on mem_gnt, go to IDLE and pulse wb_valid next cycle with wb_rd = 0.
  - Load: on mem_gnt, go to WAIT.
  - mem_req drops in the cycle after the grant.
- **WAIT.**
  - mem_rvalid is ignored in the grant cycle itself.
  - On mem_rvalid, register the extended data, go to IDLE and pulse wb_valid next cycle.
- **Store strobes and data.**
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111; wdata = wdata.
- **Load extraction.**
  - Byte: rdata >> (8·addr[1:0]), keep [7:0].
  - Halfword: rdata >> (8·addr[1:0]), keep [15:0].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- **Operation boundaries.**
  - No new operation is accepted in the same cycle that wb_valid pulses unless the state is already IDLE. The fault path and the cycle after a store grant are both IDLE, so back-to-back accepts are allowed there.
  - ex_valid with neither ex_load nor ex_store set is ignored.
- **Stray responses.** mem_rvalid and mem_gnt are ignored in IDLE.
- **Reset.** Asynchronous assertion at any point, including mid-transaction, does the following:
  - Forces IDLE.
  - Clears all outputs to 0, except lsu_ready = 1.
  - Drops any outstanding request or response; no wb_valid is produced for it.

## Timing
- Reset values:
  - state = IDLE; lsu_ready = 1.
  - mem_req, mem_we = 0; mem_addr, mem_wdata = 0; mem_wstrb = 0000.
  - wb_valid, wb_fault = 0; wb_rd = 0; wb_data = 0.
- Store latency, accept at cycle N:
  - mem_req is high from N+1.
  - Grant at cycle G ≥ N+1; wb_valid at G+1.
  - Minimum 2 cycles from accept to writeback.
- Load latency:
  - Grant at cycle G; mem_rvalid at cycle R ≥ G+1; wb_valid at R+1.
  - Minimum 3 cycles from accept to writeback.
- Fault latency: wb_valid at N+1.
- All outputs are registered; there is no combinational path from the mem_* inputs to the mem_* outputs or to lsu_ready.

## Test plan
- **SW with a 3-cycle grant stall.** SW to 0x1000, data 0xDEADBEEF, mem_gnt delayed 3 cycles → mem_req held with addr 0x1000, wstrb 1111 and data stable for the whole stall; one wb_valid one cycle after the grant, with rd = 0.
- **SB to an odd lane.** SB to 0x1003, data 0x000000A5 → wstrb 1000, wdata 0xA5A5A5A5.
- **LB versus LBU.** rdata 0x80FF7F01:
  - LB at 0x1001 → wb_data 0x0000007F.
  - LB at 0x1002 → wb_data 0xFFFFFFFF.
  - LBU at 0x1003 → wb_data 0x00000080.
- **LH and LHU.** rdata 0x8001ABCD:
  - LH at 0x1002 → wb_data 0xFFFF8001.
  - LHU at 0x1000 → wb_data 0x0000ABCD.
  - wb_rd = ex_rd in both cases; wb_valid exactly once, at rvalid cycle + 1.
- **Fault cases.** Each of LW at 0x1002, SH at 0x1001, and a load with funct3 = 011 → no mem_req ever asserted; wb_valid = 1 and wb_fault = 1 at the next cycle; lsu_ready stays 1.
- **Reset mid-load.** rst_n pulsed low while in WAIT → all outputs go to reset values immediately. A subsequent mem_rvalid produces no wb_valid. The next LW completes normally.
